// File: rtl/int_ctrl_pkg.sv
// Shared pipeline encodings for the interrupt controller, PC mux and memory stage.
package int_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAIN      = 3'd1,
        ST_PUSH_PC    = 3'd2,
        ST_PUSH_FLAGS = 3'd3,
        ST_VECTOR     = 3'd4,
        ST_POP_FLAGS  = 3'd5,
        ST_POP_PC     = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        MSEL_NONE  = 2'b00,
        MSEL_PC    = 2'b01,
        MSEL_FLAGS = 2'b10
    } mem_sel_e;

    typedef enum logic [1:0] {
        PCSEL_NORMAL = 2'b00,
        PCSEL_VECTOR = 2'b10,
        PCSEL_STACK  = 2'b11
    } pc_sel_e;

    localparam int CNT_W = 3;

endpackage

// File: rtl/int_ctrl_edge_latch.sv
// Rising-edge detector on int_req plus a single-entry pending latch.
module int_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic int_req,
    input  logic clr,
    output logic int_edge,
    output logic pending
);

    logic prev_q;
    logic pend_q;
    logic pend_d;

    assign int_edge = int_req & ~prev_q;
    assign pending  = pend_q;

    // A new edge wins over the clear so a request arriving in VECTOR is kept.
    always_comb begin
        pend_d = pend_q;
        if (clr) begin
            pend_d = 1'b0;
        end
        if (int_edge) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= int_req;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt entry/return sequencer: drains the pipe, pushes/pops PC and FLAGS.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_req,
    input  logic       rti,
    input  logic       mem_ready,
    output logic       stall,
    output logic       flush_FD,
    output logic       flush_DE,
    output logic       flush_EM,
    output logic       mem_req,
    output logic       mem_wr,
    output logic [1:0] mem_sel,
    output logic [1:0] pc_sel,
    output logic       flags_restore,
    output logic       int_ack,
    output logic       busy
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             int_edge;
    logic             pending;
    logic             clr_pend;

    assign clr_pend = (state_q == ST_VECTOR);

    int_edge_latch u_latch (
        .clk      (clk),
        .rst      (rst),
        .int_req  (int_req),
        .clr      (clr_pend),
        .int_edge (int_edge),
        .pending  (pending)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // RTI takes priority in IDLE; a simultaneous interrupt stays pending.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rti) begin
                    state_d = ST_POP_FLAGS;
                end else if (pending || int_edge) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = ST_PUSH_PC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PUSH_PC: begin
                if (mem_ready) state_d = ST_PUSH_FLAGS;
            end
            ST_PUSH_FLAGS: begin
                if (mem_ready) state_d = ST_VECTOR;
            end
            ST_VECTOR: begin
                state_d = ST_IDLE;
            end
            ST_POP_FLAGS: begin
                if (mem_ready) state_d = ST_POP_PC;
            end
            ST_POP_PC: begin
                if (mem_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        stall         = 1'b0;
        flush_FD      = 1'b0;
        flush_DE      = 1'b0;
        flush_EM      = 1'b0;
        mem_req       = 1'b0;
        mem_wr        = 1'b0;
        mem_sel       = MSEL_NONE;
        pc_sel        = PCSEL_NORMAL;
        flags_restore = 1'b0;
        int_ack       = 1'b0;
        busy          = (state_q != ST_IDLE);
        unique case (state_q)
            ST_DRAIN: begin
                stall    = 1'b1;
                flush_FD = 1'b1;
            end
            ST_PUSH_PC: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                mem_sel = MSEL_PC;
            end
            ST_PUSH_FLAGS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                mem_sel = MSEL_FLAGS;
            end
            ST_VECTOR: begin
                pc_sel   = PCSEL_VECTOR;
                int_ack  = 1'b1;
                flush_FD = 1'b1;
                flush_DE = 1'b1;
            end
            ST_POP_FLAGS: begin
                stall         = 1'b1;
                mem_req       = 1'b1;
                mem_sel       = MSEL_FLAGS;
                flags_restore = mem_ready;
            end
            ST_POP_PC: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_sel = MSEL_PC;
                // Redirect and flush only in the cycle the popped PC arrives.
                if (mem_ready) begin
                    pc_sel   = PCSEL_STACK;
                    flush_FD = 1'b1;
                    flush_DE = 1'b1;
                    flush_EM = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed scoreboard bench for int_ctrl with DRAIN_CYCLES=3.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       int_req;
    logic       rti;
    logic       mem_ready;
    logic       stall;
    logic       flush_FD;
    logic       flush_DE;
    logic       flush_EM;
    logic       mem_req;
    logic       mem_wr;
    logic [1:0] mem_sel;
    logic [1:0] pc_sel;
    logic       flags_restore;
    logic       int_ack;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int acks   = 0;
    int a0;

    // {busy,stall,fFD,fDE,fEM,mreq,mwr,msel[1:0],pcsel[1:0],frest,ack}
    localparam logic [12:0] E_IDLE   = 13'b0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [12:0] E_DRAIN  = 13'b1_1_1_0_0_0_0_00_00_0_0;
    localparam logic [12:0] E_PPC    = 13'b1_1_0_0_0_1_1_01_00_0_0;
    localparam logic [12:0] E_PFL    = 13'b1_1_0_0_0_1_1_10_00_0_0;
    localparam logic [12:0] E_VEC    = 13'b1_0_1_1_0_0_0_00_10_0_1;
    localparam logic [12:0] E_POPF   = 13'b1_1_0_0_0_1_0_10_00_0_0;
    localparam logic [12:0] E_POPF_R = 13'b1_1_0_0_0_1_0_10_00_1_0;
    localparam logic [12:0] E_POPP   = 13'b1_1_0_0_0_1_0_01_00_0_0;
    localparam logic [12:0] E_POPP_R = 13'b1_1_1_1_1_1_0_01_11_0_0;

    logic [12:0] obs;
    logic [12:0] exp_q[$];
    string       tag_q[$];

    assign obs = {busy, stall, flush_FD, flush_DE, flush_EM, mem_req,
                  mem_wr, mem_sel, pc_sel, flags_restore, int_ack};

    int_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .int_req       (int_req),
        .rti           (rti),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .flush_FD      (flush_FD),
        .flush_DE      (flush_DE),
        .flush_EM      (flush_EM),
        .mem_req       (mem_req),
        .mem_wr        (mem_wr),
        .mem_sel       (mem_sel),
        .pc_sel        (pc_sel),
        .flags_restore (flags_restore),
        .int_ack       (int_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_out();
        logic [12:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (obs[0] === 1'b1) acks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", t, obs, e);
        end
    endtask

    task automatic cyc(input logic r, input logic rdy, input logic irq,
                       input logic [12:0] e, input string tag);
        rti       = r;
        mem_ready = rdy;
        int_req   = irq;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic check_acks(input int want, input string tag);
        checks++;
        assert ((acks - a0) === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, acks - a0, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; int_req = 1'b0; rti = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 0, 0, E_IDLE, "reset");
        rst = 1'b1;
        cyc(0, 1, 0, E_IDLE, "idle");

        // Basic entry, mem_ready always high
        a0 = acks;
        cyc(0, 1, 1, E_IDLE, "irq_edge");
        repeat (3) cyc(0, 1, 1, E_DRAIN, "t1_drain");
        cyc(0, 1, 1, E_PPC, "t1_push_pc");
        cyc(0, 1, 1, E_PFL, "t1_push_flags");
        cyc(0, 1, 1, E_VEC, "t1_vector");
        cyc(0, 1, 0, E_IDLE, "t1_idle");
        cyc(0, 1, 0, E_IDLE, "t1_idle2");
        check_acks(1, "t1_acks");

        // RTI with 4 wait cycles on each pop; rti while busy ignored
        cyc(1, 0, 0, E_IDLE, "t2_rti");
        cyc(0, 0, 0, E_POPF, "t2_popf_w");
        cyc(1, 0, 0, E_POPF, "t2_popf_rti_ign");
        cyc(0, 0, 0, E_POPF, "t2_popf_w");
        cyc(0, 0, 0, E_POPF, "t2_popf_w");
        cyc(0, 1, 0, E_POPF_R, "t2_popf_rdy");
        repeat (4) cyc(0, 0, 0, E_POPP, "t2_popp_w");
        cyc(0, 1, 0, E_POPP_R, "t2_popp_rdy");
        cyc(0, 0, 0, E_IDLE, "t2_idle");
        cyc(0, 1, 0, E_IDLE, "t2_idle2");

        // RTI and interrupt edge in the same IDLE cycle
        a0 = acks;
        cyc(1, 1, 1, E_IDLE, "t3_both");
        cyc(0, 1, 1, E_POPF_R, "t3_popf");
        cyc(0, 1, 1, E_POPP_R, "t3_popp");
        cyc(0, 1, 0, E_IDLE, "t3_gap");
        repeat (3) cyc(0, 1, 0, E_DRAIN, "t3_drain");
        cyc(0, 1, 0, E_PPC, "t3_push_pc");
        cyc(0, 1, 0, E_PFL, "t3_push_flags");
        cyc(0, 1, 0, E_VEC, "t3_vector");
        cyc(0, 1, 0, E_IDLE, "t3_idle");
        cyc(0, 1, 0, E_IDLE, "t3_idle2");
        check_acks(1, "t3_acks");

        // Several edges during one RTI service: one service, rest dropped
        a0 = acks;
        cyc(1, 0, 0, E_IDLE, "t4_rti");
        cyc(0, 0, 1, E_POPF, "t4_edge1");
        cyc(0, 0, 0, E_POPF, "t4_low");
        cyc(0, 0, 1, E_POPF, "t4_edge2");
        cyc(0, 0, 0, E_POPF, "t4_low");
        cyc(0, 1, 0, E_POPF_R, "t4_popf");
        cyc(0, 0, 1, E_POPP, "t4_edge3");
        cyc(0, 1, 0, E_POPP_R, "t4_popp");
        cyc(0, 1, 0, E_IDLE, "t4_gap");
        repeat (3) cyc(0, 1, 0, E_DRAIN, "t4_drain");
        cyc(0, 1, 0, E_PPC, "t4_push_pc");
        cyc(0, 1, 0, E_PFL, "t4_push_flags");
        cyc(0, 1, 0, E_VEC, "t4_vector");
        repeat (3) cyc(0, 1, 0, E_IDLE, "t4_no_extra");
        check_acks(1, "t4_acks");

        // Asynchronous reset in the middle of PUSH_FLAGS
        cyc(0, 1, 1, E_IDLE, "t5_edge");
        repeat (3) cyc(0, 1, 1, E_DRAIN, "t5_drain");
        cyc(0, 1, 1, E_PPC, "t5_push_pc");
        cyc(0, 0, 1, E_PFL, "t5_pfl_wait");
        int_req = 1'b0;
        rst     = 1'b0;
        #1;
        checks++;
        assert (obs === E_IDLE) else begin
            errors++;
            $error("FAIL t5_async_rst observed=%b expected=%b", obs, E_IDLE);
        end
        @(posedge clk);
        #1;
        cyc(0, 0, 0, E_IDLE, "t5_in_rst");
        rst = 1'b1;
        repeat (3) cyc(0, 1, 0, E_IDLE, "t5_post_rst");

        // int_req held high through reset release: one service only
        a0  = acks;
        rst = 1'b0;
        cyc(0, 1, 1, E_IDLE, "t6_rst_hold");
        rst = 1'b1;
        cyc(0, 1, 1, E_IDLE, "t6_release");
        repeat (3) cyc(0, 1, 1, E_DRAIN, "t6_drain");
        cyc(0, 1, 1, E_PPC, "t6_push_pc");
        cyc(0, 1, 1, E_PFL, "t6_push_flags");
        cyc(0, 1, 1, E_VEC, "t6_vector");
        repeat (4) cyc(0, 1, 1, E_IDLE, "t6_idle");
        check_acks(1, "t6_acks");
        checks++;
        assert (dut.u_latch.pending === 1'b0) else begin
            errors++;
            $error("FAIL t6_pending observed=%b expected=0",
                   dut.u_latch.pending);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
